// File: rtl/nave_pkg.sv
// Shared types, constants and per-axis helper functions for the player-ship controller.
package nave_pkg;

  typedef enum logic [1:0] {
    ALIVE  = 2'd0,
    INVULN = 2'd1,
    DEAD   = 2'd2
  } nave_state_t;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  localparam int KEY_R = 0;
  localparam int KEY_L = 1;
  localparam int KEY_U = 2;
  localparam int KEY_D = 3;

  // Sums are widened to 11 bits so x+s can never wrap past the clamp.
  function automatic logic [9:0] axis_move(input logic [9:0] pos, input logic plus,
                                           input logic minus, input logic [9:0] s,
                                           input logic [9:0] lo, input logic [9:0] hi);
    logic [10:0] sum;
    logic [10:0] floor_s;
    logic [9:0]  r;
    sum     = {1'b0, pos} + {1'b0, s};
    floor_s = {1'b0, lo} + {1'b0, s};
    if (plus && !minus) begin
      if (sum > {1'b0, hi}) r = hi;
      else                  r = sum[9:0];
    end else if (minus && !plus) begin
      if ({1'b0, pos} < floor_s) r = lo;
      else                       r = pos - s;
    end else begin
      r = pos;
    end
    return r;
  endfunction

  function automatic logic [1:0] axis_dir(input logic plus, input logic minus);
    return {minus & ~plus, plus & ~minus};
  endfunction

  function automatic logic [9:0] accel_next(input logic [1:0] cur, input logic [1:0] prev,
                                            input logic [9:0] s, input logic [9:0] smax);
    logic [9:0] base;
    logic [9:0] r;
    if (cur == prev) base = s;
    else             base = 10'd1;
    if (cur == 2'b00)       r = 10'd1;
    else if (base >= smax)  r = smax;
    else                    r = base + 10'd1;
    return r;
  endfunction

endpackage

// File: rtl/nave_tick_gen.sv
// Frame-tick divider: counts 0..TICK_DIV-1 while enabled, one-clock tick on wrap.
module tick_gen #(
  parameter int TICK_DIV = 833333
) (
  input  logic CLOCK_50,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_r;

  // Divider counter, held while disabled.
  always_ff @(posedge CLOCK_50) begin
    if (clear) begin
      cnt_r <= '0;
    end else if (enable) begin
      if (cnt_r == LAST) cnt_r <= '0;
      else               cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign tick = enable && (cnt_r == LAST);

endmodule

// File: rtl/nave_ctrl.sv
// Player-ship controller: movement, lives/invulnerability, game-over and shot pacing.
// Define NAVE_ACCEL_EN for per-axis ramped step instead of a constant SPEED step.
module nave_ctrl
  import nave_pkg::*;
#(
  parameter int WIDTH         = 30,
  parameter int HEIGHT        = 30,
  parameter int X_MIN         = 0,
  parameter int X_MAX         = SCREEN_W,
  parameter int Y_MIN         = 0,
  parameter int Y_MAX         = SCREEN_H,
  parameter int X_START       = 350,
  parameter int Y_START       = 420,
  parameter int SPEED         = 2,
  parameter int TICK_DIV      = 833333,
  parameter int LIVES         = 3,
  parameter int INV_TICKS     = 120,
  parameter int BLINK_TICKS   = 8,
  parameter int FIRE_COOLDOWN = 15
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [3:0] keysout,
  input  logic       disparar,
  input  logic       pausa,
  input  logic       reiniciarJogo,
  input  logic       bateu,
  output logic [9:0] largura_nave,
  output logic [9:0] altura_nave,
  output logic [9:0] x_nave,
  output logic [9:0] y_nave,
  output logic [2:0] vidas,
  output logic       invencivel,
  output logic       visivel,
  output logic       disparo,
  output logic       game_over
);

  localparam int IW = $clog2(INV_TICKS + 1);
  localparam int BW = $clog2(BLINK_TICKS + 1);
  localparam int FW = $clog2(FIRE_COOLDOWN + 1);

  localparam logic [9:0] XLO = 10'(X_MIN);
  localparam logic [9:0] XHI = 10'(X_MAX - WIDTH);
  localparam logic [9:0] YLO = 10'(Y_MIN);
  localparam logic [9:0] YHI = 10'(Y_MAX - HEIGHT);
  localparam logic [9:0] SPD = 10'(SPEED);

  nave_state_t   state_r;
  logic [9:0]    x_r, y_r;
  logic [2:0]    vidas_r;
  logic [IW-1:0] inv_cnt_r;
  logic [BW-1:0] blink_cnt_r;
  logic [FW-1:0] cool_r;
  logic          invencivel_r, visivel_r, disparo_r, game_over_r;

  logic          clear_s, tick_s, move_en_s, hit_s, hit_dead_s, fire_s;
  logic [9:0]    step_x_s, step_y_s, nx_s, ny_s;

  assign clear_s = !reset || reiniciarJogo;

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .CLOCK_50 (CLOCK_50),
    .enable   (!pausa),
    .clear    (clear_s),
    .tick     (tick_s)
  );

`ifdef NAVE_ACCEL_EN
  logic [9:0] sx_r, sy_r;
  logic [1:0] dx_r, dy_r;
  logic [1:0] cur_dx_s, cur_dy_s;

  // Ramped step: a fresh press, a reversal or a chord restarts at 1.
  always_comb begin
    cur_dx_s = axis_dir(keysout[KEY_R], keysout[KEY_L]);
    cur_dy_s = axis_dir(keysout[KEY_D], keysout[KEY_U]);
    if ((cur_dx_s != 2'b00) && (cur_dx_s == dx_r)) step_x_s = sx_r;
    else                                           step_x_s = 10'd1;
    if ((cur_dy_s != 2'b00) && (cur_dy_s == dy_r)) step_y_s = sy_r;
    else                                           step_y_s = 10'd1;
  end

  // Per-axis acceleration state, advanced on every movement tick.
  always_ff @(posedge CLOCK_50) begin
    if (clear_s) begin
      sx_r <= 10'd1;
      sy_r <= 10'd1;
      dx_r <= 2'b00;
      dy_r <= 2'b00;
    end else if (!pausa && move_en_s) begin
      sx_r <= accel_next(cur_dx_s, dx_r, sx_r, SPD);
      sy_r <= accel_next(cur_dy_s, dy_r, sy_r, SPD);
      dx_r <= cur_dx_s;
      dy_r <= cur_dy_s;
    end else begin
      sx_r <= sx_r;
      sy_r <= sy_r;
      dx_r <= dx_r;
      dy_r <= dy_r;
    end
  end
`else
  assign step_x_s = SPD;
  assign step_y_s = SPD;
`endif

  // Next-cycle decisions; movement always sees the pre-hit state.
  always_comb begin
    move_en_s  = tick_s && (state_r != DEAD);
    hit_s      = bateu && (state_r == ALIVE);
    hit_dead_s = hit_s && (vidas_r == 3'd1);
    fire_s     = disparar && (state_r != DEAD) && (cool_r == '0) && !hit_dead_s;
    nx_s       = axis_move(x_r, keysout[KEY_R], keysout[KEY_L], step_x_s, XLO, XHI);
    ny_s       = axis_move(y_r, keysout[KEY_D], keysout[KEY_U], step_y_s, YLO, YHI);
  end

  // Ship state, lives, invulnerability timing, position and fire pacing.
  always_ff @(posedge CLOCK_50) begin
    if (clear_s) begin
      state_r      <= ALIVE;
      x_r          <= 10'(X_START);
      y_r          <= 10'(Y_START);
      vidas_r      <= 3'(LIVES);
      inv_cnt_r    <= '0;
      blink_cnt_r  <= '0;
      cool_r       <= '0;
      invencivel_r <= 1'b0;
      visivel_r    <= 1'b1;
      disparo_r    <= 1'b0;
      game_over_r  <= 1'b0;
    end else if (pausa) begin
      disparo_r <= 1'b0;
    end else begin
      disparo_r <= fire_s;
      if (fire_s)                          cool_r <= FW'(FIRE_COOLDOWN);
      else if (tick_s && (cool_r != '0))   cool_r <= cool_r - FW'(1);
      else                                 cool_r <= cool_r;
      if (move_en_s) begin
        x_r <= nx_s;
        y_r <= ny_s;
      end else begin
        x_r <= x_r;
        y_r <= y_r;
      end
      case (state_r)
        ALIVE: begin
          if (hit_s) begin
            vidas_r <= vidas_r - 3'd1;
            if (hit_dead_s) begin
              state_r     <= DEAD;
              game_over_r <= 1'b1;
            end else begin
              state_r      <= INVULN;
              invencivel_r <= 1'b1;
              inv_cnt_r    <= IW'(INV_TICKS);
              blink_cnt_r  <= BW'(BLINK_TICKS);
            end
          end
        end
        INVULN: begin
          if (tick_s) begin
            if (inv_cnt_r == IW'(1)) begin
              state_r      <= ALIVE;
              invencivel_r <= 1'b0;
              visivel_r    <= 1'b1;
              inv_cnt_r    <= '0;
            end else begin
              inv_cnt_r <= inv_cnt_r - IW'(1);
              if (blink_cnt_r == BW'(1)) begin
                visivel_r   <= ~visivel_r;
                blink_cnt_r <= BW'(BLINK_TICKS);
              end else begin
                blink_cnt_r <= blink_cnt_r - BW'(1);
              end
            end
          end
        end
        DEAD: begin
          visivel_r    <= 1'b1;
          invencivel_r <= 1'b0;
        end
        default: begin
          state_r <= ALIVE;
        end
      endcase
    end
  end

  assign largura_nave = 10'(WIDTH);
  assign altura_nave  = 10'(HEIGHT);
  assign x_nave       = x_r;
  assign y_nave       = y_r;
  assign vidas        = vidas_r;
  assign invencivel   = invencivel_r;
  assign visivel      = visivel_r;
  assign disparo      = disparo_r;
  assign game_over    = game_over_r;

endmodule

// File: tb/tb_nave_ctrl.sv
// Directed bench for nave_ctrl with a fast frame tick (TICK_DIV=4).
module tb_nave_ctrl;

  logic       CLOCK_50 = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] keysout = 4'b0000;
  logic       disparar = 1'b0;
  logic       pausa = 1'b0;
  logic       reiniciarJogo = 1'b0;
  logic       bateu = 1'b0;
  logic [9:0] largura_nave, altura_nave, x_nave, y_nave;
  logic [2:0] vidas;
  logic       invencivel, visivel, disparo, game_over;

  int n_tests = 0;
  int n_fail  = 0;
  int ph = 0;
  int tick_total = 0;

  nave_ctrl #(.TICK_DIV(4), .BLINK_TICKS(8)) dut (
    .CLOCK_50      (CLOCK_50),
    .reset         (reset),
    .keysout       (keysout),
    .disparar      (disparar),
    .pausa         (pausa),
    .reiniciarJogo (reiniciarJogo),
    .bateu         (bateu),
    .largura_nave  (largura_nave),
    .altura_nave   (altura_nave),
    .x_nave        (x_nave),
    .y_nave        (y_nave),
    .vidas         (vidas),
    .invencivel    (invencivel),
    .visivel       (visivel),
    .disparo       (disparo),
    .game_over     (game_over)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock; the bench keeps its own frame-phase model to know where ticks fall.
  task automatic clk1();
    bit t;
    t = (ph == 3) && !pausa && reset && !reiniciarJogo;
    @(posedge CLOCK_50);
    if (!reset || reiniciarJogo) ph = 0;
    else if (!pausa)             ph = (ph == 3) ? 0 : ph + 1;
    if (t) tick_total++;
    #1;
  endtask

  task automatic ticks(input int n);
    int start;
    start = tick_total;
    while (tick_total < start + n) clk1();
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int maxx, seen, t_hit, cnt, wbad, p1, p2, p3, cyc, start;
    logic prev;

    // 1. reset
    repeat (3) clk1();
    reset = 1'b1;
    chk("rst_x", x_nave, 350);
    chk("rst_y", y_nave, 420);
    chk("rst_vidas", vidas, 3);
    chk("rst_visivel", visivel, 1);
    chk("rst_game_over", game_over, 0);
    chk("rst_disparo", disparo, 0);
    chk("rst_invencivel", invencivel, 0);
    chk("largura", largura_nave, 30);
    chk("altura", altura_nave, 30);

    // 2. right to the clamp, then up to the top
    keysout = 4'b0001;
    ticks(1);   chk("x_first_step", x_nave, 352);
    ticks(129); chk("x_reach_610", x_nave, 610);
    maxx = 0;
    for (int i = 0; i < 280; i++) begin
      clk1();
      if (int'(x_nave) > maxx) maxx = int'(x_nave);
    end
    chk("x_clamp_max", maxx, 610);
    keysout = 4'b0100;
    ticks(1);   chk("y_first_step", y_nave, 418);
    ticks(209); chk("y_reach_0", y_nave, 0);
    ticks(3);   chk("y_hold_0", y_nave, 0);

    // 3. chords, then pause
    keysout = 4'b0011; ticks(3); chk("x_chord", x_nave, 610);
    keysout = 4'b1100; ticks(3); chk("y_chord", y_nave, 0);
    keysout = 4'b0010;
    pausa = 1'b1;
    bateu = 1'b1; clk1(); bateu = 1'b0;
    disparar = 1'b1;
    seen = 0;
    for (int i = 0; i < 99; i++) begin
      clk1();
      if (disparo) seen++;
    end
    chk("pause_x", x_nave, 610);
    chk("pause_vidas", vidas, 3);
    chk("pause_no_shot", seen, 0);
    disparar = 1'b0;
    pausa = 1'b0;
    while (ph != 3) clk1();
    chk("x_before_tick", x_nave, 610);
    clk1();
    chk("x_after_pause", x_nave, 608);

    // 4. hit and invulnerability window
    keysout = 4'b0000;
    bateu = 1'b1; clk1(); bateu = 1'b0;
    t_hit = tick_total;
    chk("hit1_vidas", vidas, 2);
    chk("hit1_inv", invencivel, 1);
    chk("hit1_vis", visivel, 1);
    ticks(7); chk("vis_t7", visivel, 1);
    ticks(1); chk("vis_t8", visivel, 0);
    ticks(8); chk("vis_t16", visivel, 1);
    ticks(34);
    bateu = 1'b1; clk1(); bateu = 1'b0;
    chk("hit_in_inv_ignored", vidas, 2);
    ticks(60 - (tick_total - t_hit));  chk("vis_t60", visivel, 0);
    ticks(119 - (tick_total - t_hit)); chk("inv_t119", invencivel, 1);
    ticks(1);
    chk("inv_t120", invencivel, 0);
    chk("vis_t120", visivel, 1);
    chk("vidas_t120", vidas, 2);

    // 5. down to game over
    bateu = 1'b1; clk1(); bateu = 1'b0;
    chk("hit2_vidas", vidas, 1);
    ticks(120);
    chk("hit2_inv_end", invencivel, 0);
    bateu = 1'b1; disparar = 1'b1; clk1(); bateu = 1'b0;
    chk("dead_shot_suppressed", disparo, 0);
    chk("dead_game_over", game_over, 1);
    chk("dead_vidas", vidas, 0);
    keysout = 4'b0001;
    bateu = 1'b1;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      clk1();
      if (disparo) seen++;
    end
    chk("dead_x", x_nave, 608);
    chk("dead_vidas_hold", vidas, 0);
    chk("dead_no_shot", seen, 0);
    chk("dead_vis", visivel, 1);
    bateu = 1'b0; disparar = 1'b0; keysout = 4'b0000;
    reiniciarJogo = 1'b1; clk1(); reiniciarJogo = 1'b0;
    chk("rst2_x", x_nave, 350);
    chk("rst2_y", y_nave, 420);
    chk("rst2_vidas", vidas, 3);
    chk("rst2_game_over", game_over, 0);
    chk("rst2_inv", invencivel, 0);
    chk("rst2_vis", visivel, 1);

    // 6. auto-fire pacing
    disparar = 1'b1;
    clk1();
    chk("fire_first", disparo, 1);
    cnt = 1; wbad = 0; prev = 1'b1; cyc = 0;
    p1 = 0; p2 = -1; p3 = -1;
    start = tick_total;
    while (tick_total < start + 40) begin
      clk1();
      cyc++;
      if (disparo) begin
        if (prev) wbad++;
        else begin
          cnt++;
          if (cnt == 2) p2 = cyc;
          if (cnt == 3) p3 = cyc;
        end
      end
      prev = disparo;
    end
    disparar = 1'b0;
    chk("fire_count", cnt, 3);
    chk("fire_width", wbad, 0);
    chk("fire_gap1", p2 - p1, 60);
    chk("fire_gap2", p3 - p2, 60);

    keysout = 4'b0001;
`ifdef NAVE_ACCEL_EN
    ticks(1); chk("accel_x1", x_nave, 351);
    ticks(1); chk("accel_x2", x_nave, 353);
    ticks(1); chk("accel_x3", x_nave, 355);
`else
    ticks(1); chk("step_x1", x_nave, 352);
    ticks(1); chk("step_x2", x_nave, 354);
    ticks(1); chk("step_x3", x_nave, 356);
`endif
    keysout = 4'b0000;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
